// File: rtl/enc_rr_arbiter_if.sv
// enc_rr_arbiter_if: handshake bundle between the requester bank and the
// round-robin arbiter.
//   req       requester -> arbiter, bit i = requester i
//   done      requester -> arbiter, current grantee releases the resource
//   gnt       arbiter -> bank, one-hot grant (zero when idle)
//   gnt_id    arbiter -> bank, encoded index of the set gnt bit (0 when idle)
//   gnt_valid arbiter -> bank, high while a grant is held
//   timeout   arbiter -> bank, one-cycle pulse after a tenure expired
interface enc_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, done, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/enc_rr_arbiter.sv
// enc_rr_arbiter: eight-way round-robin arbiter with bounded grant tenure.
// Reports the winner one-hot (gnt) and encoded (gnt_id, bit i <-> i).
// Every tenure is followed by one mandatory empty GAP cycle.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of enc_rr_arbiter_if (req/done in, grant outputs out)
// All outputs are registers; nothing combinational reaches them from req/done.
module enc_rr_arbiter #(
  parameter int HOLD_MAX = 16,  // max tenure in cycles, 2..255
  parameter int CW       = 8    // tenure counter width, 2^CW > HOLD_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  enc_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} st_t;

  st_t         st, st_nxt;
  logic [2:0]  ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]  gnt, gnt_nxt;
  logic [2:0]  gnt_id, gnt_id_nxt;
  logic        gnt_valid, gnt_valid_nxt;
  logic        timeout, timeout_nxt;

  // rotating-priority search result
  logic        win_found;
  logic [2:0]  win_id;
  logic [2:0]  idx;

  // release conditions while in GRANT
  logic        drop, expire, release_now;

  assign bus.gnt       = gnt;
  assign bus.gnt_id    = gnt_id;
  assign bus.gnt_valid = gnt_valid;
  assign bus.timeout   = timeout;

  // First set req bit at or after ptr, wrapping mod 8.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    idx       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign drop        = !bus.req[gnt_id];
  assign expire      = (cnt == CW'(HOLD_MAX - 1));
  assign release_now = bus.done || drop || expire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      ptr       <= 3'd0;
      cnt       <= '0;
      gnt       <= 8'h00;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      st        <= st_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    st_nxt        = st;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    unique case (st)
      IDLE: begin
        if (win_found) begin
          st_nxt        = GRANT;
          gnt_nxt       = 8'b1 << win_id;
          gnt_id_nxt    = win_id;
          gnt_valid_nxt = 1'b1;
          ptr_nxt       = win_id + 3'd1;  // wraps 7 -> 0
          cnt_nxt       = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          st_nxt        = GAP;
          gnt_nxt       = 8'h00;
          gnt_id_nxt    = 3'd0;
          gnt_valid_nxt = 1'b0;
          // only flag expiry when it was the sole reason for release
          timeout_nxt   = expire && !bus.done && !drop;
        end else begin
          cnt_nxt = cnt + CW'(1);  // cannot pass HOLD_MAX-1: expire releases first
        end
      end
      GAP: st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_enc_rr_arbiter.sv
module tb_enc_rr_arbiter;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  enc_rr_arbiter_if bus();

  enc_rr_arbiter #(.HOLD_MAX(HOLD), .CW(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = requester holding the resource (-1 none), len = cycles held so far,
  // in_gap = the mandatory empty cycle after a tenure, nextp = first requester
  // to consider in the next search.
  int  m_owner = -1, m_len = 0, nextp = 0;
  bit  in_gap = 0, m_to = 0, m_started = 0;
  int  to_cnt = 0;
  int  hist[$];   // owners in grant order
  int  lens[$];   // completed tenure lengths

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    bit rel;
    if (!rst_n) begin
      m_owner = -1; m_len = 0; nextp = 0; in_gap = 0; m_to = 0; m_started = 1;
    end else if (m_started) begin
      m_to = 0;
      if (in_gap) in_gap = 0;
      else if (m_owner < 0) begin
        w = pick(bus.req, nextp);
        if (w >= 0) begin
          m_owner = w; m_len = 1; nextp = (w + 1) % 8;
          hist.push_back(w);
        end
      end else begin
        rel = bus.done || !bus.req[m_owner] || (m_len == HOLD);
        if (rel) begin
          m_to = (m_len == HOLD) && !bus.done && bus.req[m_owner];
          if (m_to) to_cnt++;
          lens.push_back(m_len);
          m_owner = -1; in_gap = 1;
        end else m_len++;
      end
    end
  end

  // one compare process, every cycle once reset has been seen
  always @(negedge clk) begin
    if (m_started) begin
      chk("gnt",       int'(bus.gnt),       (m_owner < 0) ? 0 : (1 << m_owner));
      chk("gnt_id",    int'(bus.gnt_id),    (m_owner < 0) ? 0 : m_owner);
      chk("gnt_valid", int'(bus.gnt_valid), (m_owner < 0) ? 0 : 1);
      chk("timeout",   int'(bus.timeout),   int'(m_to));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hist.delete(); lens.delete(); to_cnt = 0;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; bus.req = 8'h00; bus.done = 1'b0;

    // reset with everything asserted
    bus.req = 8'hFF; bus.done = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_gnt", int'(bus.gnt), 0);
    chk("reset_id",  int'(bus.gnt_id), 0);
    chk("reset_vld", int'(bus.gnt_valid), 0);
    rst_n = 1'b1; bus.done = 1'b0; bus.req = 8'h00;
    hist.delete(); lens.delete(); to_cnt = 0;

    // fairness: req all, done on second grant cycle
    bus.req = 8'hFF;
    repeat (36) begin
      @(negedge clk);
      bus.done = (m_owner >= 0 && m_len == 2);
    end
    bus.req = 8'h00; bus.done = 1'b0;
    repeat (4) @(negedge clk);
    chk("fair_count", (hist.size() >= 9) ? 1 : 0, 1);
    for (int i = 0; i < 9 && i < hist.size(); i++) chk("fair_order", hist[i], i % 8);
    for (int i = 0; i < lens.size(); i++) chk("fair_len", lens[i], 2);

    // sparse wrap 1,7,1,7
    do_reset();
    bus.req = 8'b1000_0010;
    repeat (16) begin
      @(negedge clk);
      bus.done = (m_owner >= 0 && m_len == 1);
    end
    bus.req = 8'h00; bus.done = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrap_count", (hist.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4 && i < hist.size(); i++) chk("wrap_order", hist[i], (i % 2) ? 7 : 1);

    // timeout: requester 2 held, never done
    do_reset();
    bus.req = 8'h04;
    repeat (14) @(negedge clk);
    chk("to_lens", lens.size(), 2);
    if (lens.size() >= 2) begin
      chk("to_len0", lens[0], HOLD);
      chk("to_len1", lens[1], HOLD);
    end
    chk("to_pulses", to_cnt, 2);
    chk("to_owner", hist[0], 2);
    chk("to_regrant", (hist.size() >= 2) ? hist[1] : -1, 2);
    bus.req = 8'h00;
    repeat (3) @(negedge clk);

    // release race on final cycle, then done during GAP
    do_reset();
    bus.req = 8'h04;
    repeat (14) begin
      @(negedge clk);
      if (m_owner >= 0 && m_len == HOLD && hist.size() == 1) begin
        bus.done = 1'b1; bus.req = 8'h00;
      end else if (in_gap) begin
        bus.done = 1'b1; bus.req = 8'h04;
      end else begin
        bus.done = 1'b0; bus.req = 8'h04;
      end
    end
    bus.req = 8'h00; bus.done = 1'b0;
    repeat (3) @(negedge clk);
    chk("race_tenures", (lens.size() >= 2) ? 1 : 0, 1);
    if (lens.size() >= 2) begin
      chk("race_len0", lens[0], HOLD);
      chk("race_len1", lens[1], HOLD);
    end
    chk("race_to", to_cnt, 1);

    // reset in middle of requester 5's tenure
    do_reset();
    bus.req = 8'h21;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_owner == 5 && m_len == 2) found = 1;
      else bus.done = (m_owner == 0 && m_len == 1);
    end
    chk("rst_mid_reached", int'(found), 1);
    bus.done = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_gnt", int'(bus.gnt), 0);
    chk("rst_mid_vld", int'(bus.gnt_valid), 0);
    rst_n = 1'b1;
    hist.delete();
    for (int i = 0; i < 10 && hist.size() == 0; i++) @(negedge clk);
    chk("rst_mid_first", (hist.size() > 0) ? hist[0] : -1, 0);
    bus.req = 8'h00;
    repeat (3) @(negedge clk);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(199) != 0);
      if ($urandom_range(5) == 0) bus.req = 8'($urandom);
      bus.done = ($urandom_range(4) == 0);
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
